// File: rtl/piezo_sched_pkg.sv
// Shared types and constants for the piezo sound scheduler: state encoding,
// grant bit positions, tone half-period settings and chime count helpers.
package piezo_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ALARM     = 3'd1,
        ST_TIMER     = 3'd2,
        ST_CHIME_ON  = 3'd3,
        ST_CHIME_OFF = 3'd4,
        ST_CLICK     = 3'd5
    } sched_state_e;

    localparam int unsigned GNT_W     = 4;
    localparam int unsigned GNT_ALARM = 3;
    localparam int unsigned GNT_TIMER = 2;
    localparam int unsigned GNT_CHIME = 1;
    localparam int unsigned GNT_CLICK = 0;

    localparam int unsigned HALF_W = 2;
    localparam logic [HALF_W-1:0] HALF_CLICK = 2'd0;
    localparam logic [HALF_W-1:0] HALF_TIMER = 2'd1;
    localparam logic [HALF_W-1:0] HALF_CHIME = 2'd2;

    localparam int unsigned COUNT_W = 4;
    localparam logic [COUNT_W-1:0] CHIME_MAX = 4'd12;

    // Out-of-range hour counts ring the full twelve.
    function automatic logic [COUNT_W-1:0] chime_sat(input logic [COUNT_W-1:0] c);
        return ((c == '0) || (c > CHIME_MAX)) ? CHIME_MAX : c;
    endfunction

    function automatic logic [GNT_W-1:0] grant_of(input sched_state_e s);
        logic [GNT_W-1:0] g;
        g = '0;
        case (s)
            ST_ALARM:     g[GNT_ALARM] = 1'b1;
            ST_TIMER:     g[GNT_TIMER] = 1'b1;
            ST_CHIME_ON:  g[GNT_CHIME] = 1'b1;
            ST_CHIME_OFF: g[GNT_CHIME] = 1'b1;
            ST_CLICK:     g[GNT_CLICK] = 1'b1;
            default:      g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave tone generator toggling every half+1 cycles; can also pass an
// external level straight to its registered output.
module piezo_tone_gen
    import piezo_sched_pkg::*;
(
    input  logic              clk_1k,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              en,
    input  logic              pass_en,
    input  logic              pass_val,
    input  logic [HALF_W-1:0] half,
    output logic              tone
);

    logic [HALF_W-1:0] cnt;

    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tone <= 1'b0;
        end else if (pass_en) begin
            cnt  <= '0;
            tone <= pass_val;
        end else if (en) begin
            if (cnt == half) begin
                cnt  <= '0;
                tone <= ~tone;
            end else begin
                cnt <= cnt + HALF_W'(1);
            end
        end
    end

endmodule

// File: rtl/piezo_sound_scheduler.sv
// Fixed-priority arbiter and cadence sequencer sharing the single piezo
// between alarm melody, timer beep, hourly chime and key click.
module piezo_sound_scheduler #(
    parameter int unsigned CLICK_MS     = 20,
    parameter int unsigned CHIME_ON_MS  = 200,
    parameter int unsigned CHIME_OFF_MS = 300,
    parameter int unsigned TIMER_ON_MS  = 250,
    parameter int unsigned TIMER_OFF_MS = 250
) (
    input  logic       clk_1k,
    input  logic       rst_n,
    input  logic       mute,
    input  logic       alarm_req,
    input  logic       alarm_tone,
    input  logic       timer_req,
    input  logic       chime_trig,
    input  logic [3:0] chime_count,
    input  logic       click_trig,
    output logic       piezo,
    output logic [3:0] grant,
    output logic       busy
);
    import piezo_sched_pkg::*;

    localparam int unsigned MAX_A   = (CLICK_MS > CHIME_ON_MS) ? CLICK_MS : CHIME_ON_MS;
    localparam int unsigned MAX_B   = (CHIME_OFF_MS > TIMER_ON_MS) ? CHIME_OFF_MS : TIMER_ON_MS;
    localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned DUR_MAX = (MAX_AB > TIMER_OFF_MS) ? MAX_AB : TIMER_OFF_MS;
    localparam int unsigned DUR_W   = $clog2(DUR_MAX + 1);

    sched_state_e         state, state_d;
    logic [DUR_W-1:0]     dur, dur_d, phase_last_c;
    logic                 timer_off, timer_off_d;
    logic                 chime_pend, chime_pend_d;
    logic [COUNT_W-1:0]   chime_left, chime_left_d;
    logic                 chime_ok_c, click_ok_c, phase_end_c;
    logic                 in_chime_c, in_seq_c, chime_start_c, preempt_c;
    logic                 tone_clear_c, tone_en_c, tone_pass_c;
    logic [HALF_W-1:0]    tone_half_c;

    // Last cycle index of the current timed phase.
    always_comb begin
        phase_last_c = '0;
        case (state)
            ST_CLICK:     phase_last_c = DUR_W'(CLICK_MS - 1);
            ST_CHIME_ON:  phase_last_c = DUR_W'(CHIME_ON_MS - 1);
            ST_CHIME_OFF: phase_last_c = DUR_W'(CHIME_OFF_MS - 1);
            ST_TIMER:     phase_last_c = timer_off ? DUR_W'(TIMER_OFF_MS - 1)
                                                   : DUR_W'(TIMER_ON_MS - 1);
            default:      phase_last_c = '0;
        endcase
    end

    always_comb begin
        state_d       = state;
        dur_d         = dur + DUR_W'(1);
        timer_off_d   = timer_off;
        chime_pend_d  = chime_pend;
        chime_left_d  = chime_left;
        chime_ok_c    = chime_trig && !mute;
        click_ok_c    = click_trig && !mute;
        phase_end_c   = (dur == phase_last_c);
        in_chime_c    = (state == ST_CHIME_ON) || (state == ST_CHIME_OFF);
        in_seq_c      = in_chime_c || (state == ST_CLICK);

        if (alarm_req) begin
            state_d = ST_ALARM;
        end else if (timer_req && (state != ST_ALARM)) begin
            state_d = ST_TIMER;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!mute && (chime_pend || chime_ok_c)) state_d = ST_CHIME_ON;
                    else if (click_ok_c)                     state_d = ST_CLICK;
                end
                ST_ALARM: state_d = timer_req ? ST_TIMER : ST_IDLE;
                ST_TIMER: state_d = ST_IDLE;
                ST_CHIME_ON: begin
                    if (mute) state_d = ST_IDLE;
                    else if (phase_end_c)
                        state_d = (chime_left <= COUNT_W'(1)) ? ST_IDLE : ST_CHIME_OFF;
                end
                ST_CHIME_OFF: begin
                    if (mute)             state_d = ST_IDLE;
                    else if (phase_end_c) state_d = ST_CHIME_ON;
                end
                ST_CLICK: begin
                    if (mute) state_d = ST_IDLE;
                    else if (phase_end_c)
                        state_d = (chime_pend || chime_ok_c) ? ST_CHIME_ON : ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        chime_start_c = (state_d == ST_CHIME_ON) && !in_chime_c;
        preempt_c     = in_seq_c && ((state_d == ST_ALARM) || (state_d == ST_TIMER));

        if ((state_d != state) || (state_d == ST_IDLE) || (state_d == ST_ALARM)) begin
            dur_d       = '0;
            timer_off_d = 1'b0;
        end else if ((state == ST_TIMER) && phase_end_c) begin
            dur_d       = '0;
            timer_off_d = !timer_off;
        end

        if (chime_ok_c && !in_chime_c) chime_pend_d = 1'b1;
        if (mute || chime_start_c || preempt_c) chime_pend_d = 1'b0;

        if (chime_ok_c)
            chime_left_d = chime_sat(chime_count);
        else if ((state == ST_CHIME_ON) && phase_end_c && (chime_left != '0))
            chime_left_d = chime_left - COUNT_W'(1);

        // Tone restarts from zero on every entry and stays low through silence.
        tone_clear_c = (state_d != state) || (state_d == ST_IDLE) ||
                       (state_d == ST_CHIME_OFF) || ((state_d == ST_TIMER) && timer_off_d);
        tone_en_c    = (state == ST_CLICK) || (state == ST_CHIME_ON) ||
                       ((state == ST_TIMER) && !timer_off);
        tone_pass_c  = (state == ST_ALARM);
        case (state)
            ST_TIMER: tone_half_c = HALF_TIMER;
            ST_CLICK: tone_half_c = HALF_CLICK;
            default:  tone_half_c = HALF_CHIME;
        endcase
    end

    always_ff @(posedge clk_1k or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dur        <= '0;
            timer_off  <= 1'b0;
            chime_pend <= 1'b0;
            chime_left <= '0;
            grant      <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            dur        <= dur_d;
            timer_off  <= timer_off_d;
            chime_pend <= chime_pend_d;
            chime_left <= chime_left_d;
            grant      <= grant_of(state_d);
            busy       <= (state_d != ST_IDLE);
        end
    end

    piezo_tone_gen u_tone (
        .clk_1k   (clk_1k),
        .rst_n    (rst_n),
        .clear    (tone_clear_c),
        .en       (tone_en_c),
        .pass_en  (tone_pass_c),
        .pass_val (alarm_tone),
        .half     (tone_half_c),
        .tone     (piezo)
    );

endmodule

// File: tb/tb_piezo_sound_scheduler.sv
// Bench for piezo_sound_scheduler: directed scenarios plus random traffic,
// compared every cycle against a phase/countdown reference model.
module tb_piezo_sound_scheduler;

    localparam int CLICK_MS     = 20;
    localparam int CHIME_ON_MS  = 200;
    localparam int CHIME_OFF_MS = 300;
    localparam int TIMER_ON_MS  = 250;
    localparam int TIMER_OFF_MS = 250;

    localparam int S_IDLE  = 0;
    localparam int S_ALARM = 1;
    localparam int S_TIMER = 2;
    localparam int S_CHIME = 3;
    localparam int S_CLICK = 4;

    logic       clk_1k = 1'b0;
    logic       rst_n, mute, alarm_req, alarm_tone, timer_req, chime_trig, click_trig;
    logic [3:0] chime_count;
    logic       piezo, busy;
    logic [3:0] grant;

    always #5 clk_1k = ~clk_1k;

    piezo_sound_scheduler #(
        .CLICK_MS     (CLICK_MS),
        .CHIME_ON_MS  (CHIME_ON_MS),
        .CHIME_OFF_MS (CHIME_OFF_MS),
        .TIMER_ON_MS  (TIMER_ON_MS),
        .TIMER_OFF_MS (TIMER_OFF_MS)
    ) dut (
        .clk_1k      (clk_1k),
        .rst_n       (rst_n),
        .mute        (mute),
        .alarm_req   (alarm_req),
        .alarm_tone  (alarm_tone),
        .timer_req   (timer_req),
        .chime_trig  (chime_trig),
        .chime_count (chime_count),
        .click_trig  (click_trig),
        .piezo       (piezo),
        .grant       (grant),
        .busy        (busy)
    );

    // Reference model: current owner, on/off phase, cycles left in phase,
    // cycles elapsed in phase, chime beeps left, pending chime, alarm echo.
    int   m_src, m_rem, m_k, m_beeps;
    bit   m_on, m_pend, m_apz;
    int   n_vec, n_err, rises, busy_cyc;
    logic prev_piezo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int sat(input logic [3:0] c);
        return ((c == 4'd0) || (c > 4'd12)) ? 12 : int'(c);
    endfunction

    function automatic int len_of(input int s);
        case (s)
            S_CLICK: return CLICK_MS;
            S_CHIME: return CHIME_ON_MS;
            S_TIMER: return TIMER_ON_MS;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_grant();
        case (m_src)
            S_ALARM: return 8;
            S_TIMER: return 4;
            S_CHIME: return 2;
            S_CLICK: return 1;
            default: return 0;
        endcase
    endfunction

    // Square wave with half period h+1, low for the first h+1 cycles of a phase.
    function automatic int exp_piezo();
        int h;
        if (m_src == S_ALARM) return int'(m_apz);
        if (!m_on) return 0;
        case (m_src)
            S_CLICK: h = 0;
            S_TIMER: h = 1;
            S_CHIME: h = 2;
            default: return 0;
        endcase
        return (m_k / (h + 1)) % 2;
    endfunction

    task automatic model_reset();
        m_src = S_IDLE; m_rem = 0; m_k = 0; m_beeps = 0;
        m_on = 1'b0; m_pend = 1'b0; m_apz = 1'b0;
    endtask

    task automatic model_step();
        int nsrc, nrem, nk, nbeeps;
        bit non, npend, start, chime_ok, click_ok;
        chime_ok = chime_trig && !mute;
        click_ok = click_trig && !mute;
        start    = 1'b0;
        nsrc = m_src; non = m_on; nrem = m_rem - 1; nk = m_k + 1;
        if (alarm_req) nsrc = S_ALARM;
        else if (timer_req && m_src != S_ALARM) nsrc = S_TIMER;
        else begin
            case (m_src)
                S_IDLE: begin
                    if (!mute && (m_pend || chime_ok)) start = 1'b1;
                    else if (click_ok) nsrc = S_CLICK;
                end
                S_ALARM: nsrc = timer_req ? S_TIMER : S_IDLE;
                S_TIMER: nsrc = S_IDLE;
                S_CHIME: begin
                    if (mute) nsrc = S_IDLE;
                    else if (m_rem == 1) begin
                        if (!m_on) begin non = 1'b1; nrem = CHIME_ON_MS; nk = 0; end
                        else if (m_beeps <= 1) nsrc = S_IDLE;
                        else begin non = 1'b0; nrem = CHIME_OFF_MS; nk = 0; end
                    end
                end
                S_CLICK: begin
                    if (mute) nsrc = S_IDLE;
                    else if (m_rem == 1) begin
                        if (m_pend || chime_ok) start = 1'b1;
                        else nsrc = S_IDLE;
                    end
                end
                default: nsrc = S_IDLE;
            endcase
        end
        if (start) nsrc = S_CHIME;
        if (nsrc != m_src) begin
            non = 1'b1; nk = 0; nrem = len_of(nsrc);
        end else if (m_src == S_TIMER && m_rem == 1) begin
            non = !m_on; nk = 0; nrem = non ? TIMER_ON_MS : TIMER_OFF_MS;
        end
        npend = m_pend;
        if (chime_ok && m_src != S_CHIME) npend = 1'b1;
        if (mute || start || ((m_src == S_CHIME || m_src == S_CLICK) &&
                              (nsrc == S_ALARM || nsrc == S_TIMER))) npend = 1'b0;
        nbeeps = m_beeps;
        if (chime_ok) nbeeps = sat(chime_count);
        else if (m_src == S_CHIME && m_on && m_rem == 1 && m_beeps > 0) nbeeps = m_beeps - 1;
        m_apz   = (m_src == S_ALARM && nsrc == S_ALARM) ? alarm_tone : 1'b0;
        m_src   = nsrc; m_on = non; m_rem = nrem; m_k = nk;
        m_pend  = npend; m_beeps = nbeeps;
    endtask

    task automatic step_cycle();
        model_step();
        @(posedge clk_1k);
        @(negedge clk_1k);
        chk("piezo", 32'(piezo), 32'(exp_piezo()));
        chk("grant", 32'(grant), 32'(exp_grant()));
        chk("busy",  32'(busy),  32'(exp_grant() != 0));
        if (piezo && !prev_piezo) rises++;
        if (busy) busy_cyc++;
        prev_piezo = piezo;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cycle();
    endtask

    task automatic clear_stats();
        rises = 0; busy_cyc = 0; prev_piezo = piezo;
    endtask

    task automatic pulse_chime(input logic [3:0] c);
        chime_count = c; chime_trig = 1'b1;
        step_cycle();
        chime_trig = 1'b0;
    endtask

    task automatic pulse_click();
        click_trig = 1'b1;
        step_cycle();
        click_trig = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mute = 1'b0; alarm_req = 1'b0; alarm_tone = 1'b0; timer_req = 1'b0;
        chime_trig = 1'b0; chime_count = 4'd0; click_trig = 1'b0;
        n_vec = 0; n_err = 0; prev_piezo = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_1k);
        chk("rst_piezo", 32'(piezo), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        rst_n = 1'b1;
        run(5);

        // Click from idle
        clear_stats();
        pulse_click();
        run(24);
        chk("click_rises", 32'(rises), 32'd10);
        chk("click_busy",  32'(busy_cyc), 32'd20);

        // Three-beep chime
        clear_stats();
        pulse_chime(4'd3);
        run(1210);
        chk("chime3_busy",  32'(busy_cyc), 32'd1200);
        chime_count = 4'd0;
        chk("chime3_rises", 32'(rises), 32'd99);

        // Count 0 rings twelve
        clear_stats();
        pulse_chime(4'd0);
        run(5710);
        chk("chime12_busy", 32'(busy_cyc), 32'd5700);

        // Timer preempted by alarm mid-tone, then resumed
        timer_req = 1'b1;
        run(520);
        alarm_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            alarm_tone = 1'($urandom);
            step_cycle();
        end
        alarm_req = 1'b0; alarm_tone = 1'b0;
        run(300);
        timer_req = 1'b0;
        run(10);

        // Contention cases
        chime_count = 4'd1; chime_trig = 1'b1; click_trig = 1'b1;
        step_cycle();
        chime_trig = 1'b0; click_trig = 1'b0;
        chk("chime_over_click", 32'(grant), 32'd2);
        run(210);
        pulse_chime(4'd2);
        run(250);
        pulse_click();
        run(500);
        pulse_click();
        run(5);
        pulse_chime(4'd1);
        run(230);

        // Mute aborts a chime, blocks clicks, spares the timer
        pulse_chime(4'd3);
        run(549);
        mute = 1'b1;
        step_cycle();
        chk("mute_abort", 32'(grant), 32'd0);
        mute = 1'b0;
        run(900);
        mute = 1'b1;
        pulse_click();
        run(5);
        timer_req = 1'b1;
        run(300);
        timer_req = 1'b0; mute = 1'b0;
        run(10);

        // Asynchronous reset mid-chime
        pulse_chime(4'd4);
        run(100);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_piezo", 32'(piezo), 32'd0);
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_busy",  32'(busy),  32'd0);
        model_reset();
        @(negedge clk_1k);
        rst_n = 1'b1;
        prev_piezo = piezo;
        run(50);

        // Random traffic
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 799) == 0) alarm_req = !alarm_req;
            if ($urandom_range(0, 599) == 0) timer_req = !timer_req;
            if (mute) begin
                if ($urandom_range(0, 19) == 0) mute = 1'b0;
            end else if ($urandom_range(0, 699) == 0) mute = 1'b1;
            chime_trig  = ($urandom_range(0, 299) == 0);
            chime_count = 4'($urandom_range(0, 15));
            click_trig  = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 2) == 0) alarm_tone = !alarm_tone;
            step_cycle();
        end
        alarm_req = 1'b0; timer_req = 1'b0; mute = 1'b0;
        chime_trig = 1'b0; click_trig = 1'b0;
        run(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
